// File: rtl/nvdla_snap_intr_bridge.sv
`default_nettype none
// ============================================================================
// Module   : nvdla_snap_intr_bridge
// Purpose  : Turns the level-sensitive NVDLA core interrupt into the SNAP
//            action interrupt request/acknowledge handshake. It qualifies
//            edges, latches source/context, retries on ack timeout, applies
//            a rearm hold-off and keeps status.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   ap_clk         in   sole clock
//   ap_rst         in   asynchronous reset, active high
//   dla_intr_i     in   NVDLA level interrupt (high until status cleared)
//   cfg_enable     in   1 = delivery allowed, 0 = events held pending
//   cfg_src        in   source code presented on interrupt_src
//   cfg_ctx        in   context presented on interrupt_ctx
//   cfg_clr_stat   in   1-cycle pulse, clears stat_timeout / stat_intr_cnt
//   interrupt      out  SNAP interrupt request
//   interrupt_src  out  latched source, stable while interrupt=1
//   interrupt_ctx  out  latched context, stable while interrupt=1
//   interrupt_ack  in   SNAP acknowledge, 1-cycle pulse
//   stat_pending   out  event captured, not yet acknowledged
//   stat_timeout   out  sticky, at least one ack timeout occurred
//   stat_intr_cnt  out  acknowledged interrupts, saturating
// ============================================================================
module nvdla_snap_intr_bridge #(
  parameter int INT_BITS     = 3,
  parameter int CONTEXT_BITS = 8,
  parameter int ACK_TIMEOUT  = 1024,
  parameter int HOLDOFF      = 16,
  parameter int CNT_W        = 16
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    dla_intr_i,
  input  logic                    cfg_enable,
  input  logic [INT_BITS-2:0]     cfg_src,
  input  logic [CONTEXT_BITS-1:0] cfg_ctx,
  input  logic                    cfg_clr_stat,
  output logic                    interrupt,
  output logic [INT_BITS-2:0]     interrupt_src,
  output logic [CONTEXT_BITS-1:0] interrupt_ctx,
  input  logic                    interrupt_ack,
  output logic                    stat_pending,
  output logic                    stat_timeout,
  output logic [CNT_W-1:0]        stat_intr_cnt
);

  localparam int ACK_W  = $clog2(ACK_TIMEOUT);
  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic                    dla_q;
  // Low only in the first cycle after reset: a level that is already high
  // when reset releases belongs to an event that reset discarded, so it must
  // not be mistaken for a fresh rising edge.
  logic                    sampled;
  logic                    pending,  pending_nxt;
  logic                    irq_nxt;
  logic [INT_BITS-2:0]     src_nxt;
  logic [CONTEXT_BITS-1:0] ctx_nxt;
  logic [ACK_W-1:0]        ack_tmr,  ack_tmr_nxt;
  logic [HOLD_W-1:0]       hold_tmr, hold_tmr_nxt;
  logic                    tout_nxt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic                    rise;

  assign rise         = sampled & dla_intr_i & ~dla_q;
  assign stat_pending = pending;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state         <= IDLE;
      dla_q         <= 1'b0;
      sampled       <= 1'b0;
      pending       <= 1'b0;
      interrupt     <= 1'b0;
      interrupt_src <= '0;
      interrupt_ctx <= '0;
      ack_tmr       <= '0;
      hold_tmr      <= '0;
      stat_timeout  <= 1'b0;
      stat_intr_cnt <= '0;
    end else begin
      state         <= state_nxt;
      dla_q         <= dla_intr_i;
      sampled       <= 1'b1;
      pending       <= pending_nxt;
      interrupt     <= irq_nxt;
      interrupt_src <= src_nxt;
      interrupt_ctx <= ctx_nxt;
      ack_tmr       <= ack_tmr_nxt;
      hold_tmr      <= hold_tmr_nxt;
      stat_timeout  <= tout_nxt;
      stat_intr_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pending_nxt  = pending;
    irq_nxt      = interrupt;
    src_nxt      = interrupt_src;
    ctx_nxt      = interrupt_ctx;
    ack_tmr_nxt  = ack_tmr;
    hold_tmr_nxt = hold_tmr;
    tout_nxt     = stat_timeout;
    cnt_nxt      = stat_intr_cnt;

    unique case (state)
      IDLE: begin
        if (pending && cfg_enable) begin
          state_nxt   = REQ;
          irq_nxt     = 1'b1;
          src_nxt     = cfg_src;
          ctx_nxt     = cfg_ctx;
          ack_tmr_nxt = '0;
        end
      end

      REQ: begin
        if (interrupt_ack) begin
          // Accepted whether the request is up or in its timeout drop cycle.
          state_nxt   = WAIT_LOW;
          irq_nxt     = 1'b0;
          pending_nxt = 1'b0;
          ack_tmr_nxt = '0;
          cnt_nxt     = (stat_intr_cnt == CNT_MAX) ? stat_intr_cnt
                                                   : stat_intr_cnt + 1'b1;
        end else if (!interrupt) begin
          // One-cycle drop after a timeout is over: re-raise with the same
          // latched source/context and a fresh timer.
          irq_nxt = 1'b1;
        end else if (ack_tmr == ACK_LAST) begin
          irq_nxt     = 1'b0;
          ack_tmr_nxt = '0;
          tout_nxt    = 1'b1;
        end else begin
          ack_tmr_nxt = ack_tmr + 1'b1;
        end
      end

      WAIT_LOW: begin
        if (!dla_intr_i) begin
          state_nxt    = HOLD;
          hold_tmr_nxt = '0;
        end
      end

      HOLD: begin
        // Any high sample restarts the hold-off so a bouncing level cannot
        // rearm the bridge early.
        if (dla_intr_i) begin
          hold_tmr_nxt = '0;
        end else if (hold_tmr == HOLD_LAST) begin
          state_nxt = IDLE;
        end else begin
          hold_tmr_nxt = hold_tmr + 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // A new edge always wins over the ack's pending clear so that an event
    // arriving in the ack cycle is serviced after the hold-off.
    if (rise) begin
      pending_nxt = 1'b1;
    end

    if (cfg_clr_stat) begin
      tout_nxt = 1'b0;
      cnt_nxt  = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nvdla_snap_intr_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_nvdla_snap_intr_bridge
// Purpose  : Directed self-checking bench for nvdla_snap_intr_bridge, built
//            with a short ack timeout, short hold-off and a 4-bit counter so
//            that timeout and saturation are reachable quickly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nvdla_snap_intr_bridge;

  localparam int INT_BITS     = 3;
  localparam int CONTEXT_BITS = 8;
  localparam int ACK_TIMEOUT  = 8;
  localparam int HOLDOFF      = 4;
  localparam int CNT_W        = 4;

  logic                    ap_clk = 1'b0;
  logic                    ap_rst;
  logic                    dla_intr_i;
  logic                    cfg_enable;
  logic [INT_BITS-2:0]     cfg_src;
  logic [CONTEXT_BITS-1:0] cfg_ctx;
  logic                    cfg_clr_stat;
  logic                    interrupt;
  logic [INT_BITS-2:0]     interrupt_src;
  logic [CONTEXT_BITS-1:0] interrupt_ctx;
  logic                    interrupt_ack;
  logic                    stat_pending;
  logic                    stat_timeout;
  logic [CNT_W-1:0]        stat_intr_cnt;

  int tests = 0;
  int fails = 0;

  nvdla_snap_intr_bridge #(
    .INT_BITS     (INT_BITS),
    .CONTEXT_BITS (CONTEXT_BITS),
    .ACK_TIMEOUT  (ACK_TIMEOUT),
    .HOLDOFF      (HOLDOFF),
    .CNT_W        (CNT_W)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .dla_intr_i    (dla_intr_i),
    .cfg_enable    (cfg_enable),
    .cfg_src       (cfg_src),
    .cfg_ctx       (cfg_ctx),
    .cfg_clr_stat  (cfg_clr_stat),
    .interrupt     (interrupt),
    .interrupt_src (interrupt_src),
    .interrupt_ctx (interrupt_ctx),
    .interrupt_ack (interrupt_ack),
    .stat_pending  (stat_pending),
    .stat_timeout  (stat_timeout),
    .stat_intr_cnt (stat_intr_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ap_clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete interrupt from an idle bridge with the level low.
  task automatic service();
    dla_intr_i = 1'b1;
    tick(2);
    check("svc_irq", interrupt, 1);
    interrupt_ack = 1'b1;
    tick(1);
    interrupt_ack = 1'b0;
    dla_intr_i    = 1'b0;
    tick(7);
  endtask

  initial begin
    ap_rst        = 1'b1;
    dla_intr_i    = 1'b0;
    cfg_enable    = 1'b1;
    cfg_src       = 2'd2;
    cfg_ctx       = 8'hA5;
    cfg_clr_stat  = 1'b0;
    interrupt_ack = 1'b0;
    tick(2);

    // Reset state
    check("rst_irq",  interrupt,     0);
    check("rst_pend", stat_pending,  0);
    check("rst_tout", stat_timeout,  0);
    check("rst_cnt",  stat_intr_cnt, 0);
    check("rst_ctx",  interrupt_ctx, 0);
    check("rst_src",  interrupt_src, 0);
    ap_rst = 1'b0;
    tick(3);

    // Basic handshake: rise -> pending next cycle -> interrupt one cycle later
    dla_intr_i = 1'b1;
    tick(1);
    check("t1_pend",     stat_pending, 1);
    check("t1_irq_lat",  interrupt,    0);
    tick(1);
    check("t1_irq",      interrupt,     1);
    check("t1_ctx",      interrupt_ctx, 8'hA5);
    check("t1_src",      interrupt_src, 2);
    cfg_ctx = 8'h3C;
    cfg_src = 2'd1;
    tick(1);
    check("t1_irq_hold", interrupt,     1);
    check("t1_ctx_hold", interrupt_ctx, 8'hA5);
    interrupt_ack = 1'b1;
    tick(1);
    interrupt_ack = 1'b0;
    check("t1_irq_drop", interrupt,     0);
    check("t1_cnt",      stat_intr_cnt, 1);
    check("t1_pend_clr", stat_pending,  0);
    dla_intr_i = 1'b0;
    tick(8);

    // Ack timeout: 8 cycles high, 1 low, re-raise with same latched context
    dla_intr_i = 1'b1;
    tick(2);
    check("t2_irq",       interrupt,     1);
    check("t2_ctx",       interrupt_ctx, 8'h3C);
    cfg_ctx = 8'h77;
    tick(7);
    check("t2_irq_last",  interrupt,    1);
    check("t2_tout_pre",  stat_timeout, 0);
    tick(1);
    check("t2_irq_gap",   interrupt,    0);
    check("t2_tout",      stat_timeout, 1);
    tick(1);
    check("t2_irq_again", interrupt,     1);
    check("t2_ctx_again", interrupt_ctx, 8'h3C);
    tick(8);
    check("t2_irq_gap2",  interrupt,    0);
    // Ack arriving in the drop cycle is still a valid ack
    interrupt_ack = 1'b1;
    tick(1);
    interrupt_ack = 1'b0;
    check("t2_cnt",       stat_intr_cnt, 2);
    check("t2_pend",      stat_pending,  0);
    tick(1);
    check("t2_no_reraise", interrupt, 0);
    dla_intr_i = 1'b0;
    tick(8);
    cfg_clr_stat = 1'b1;
    tick(1);
    cfg_clr_stat = 1'b0;
    check("clr_cnt",  stat_intr_cnt, 0);
    check("clr_tout", stat_timeout,  0);

    // Disabled delivery holds the event pending
    cfg_enable = 1'b0;
    dla_intr_i = 1'b1;
    tick(1);
    dla_intr_i = 1'b0;
    tick(5);
    check("t3_irq_off", interrupt,    0);
    check("t3_pend",    stat_pending, 1);
    cfg_enable = 1'b1;
    tick(1);
    check("t3_irq_en",  interrupt, 1);
    interrupt_ack = 1'b1;
    tick(1);
    interrupt_ack = 1'b0;
    check("t3_cnt",     stat_intr_cnt, 1);
    tick(8);

    // Second rise while waiting for the level to drop
    dla_intr_i = 1'b1;
    tick(2);
    check("t4_irq1", interrupt, 1);
    dla_intr_i    = 1'b0;
    interrupt_ack = 1'b1;
    tick(1);
    interrupt_ack = 1'b0;
    dla_intr_i    = 1'b1;
    tick(1);
    check("t4_pend",  stat_pending,  1);
    check("t4_irq0",  interrupt,     0);
    check("t4_cnt1",  stat_intr_cnt, 2);
    tick(3);
    dla_intr_i = 1'b0;
    // Registered level goes low next cycle; request follows HOLDOFF+1 later
    tick(5);
    check("t4_holdoff", interrupt, 0);
    tick(1);
    check("t4_irq2",    interrupt, 1);
    interrupt_ack = 1'b1;
    tick(1);
    interrupt_ack = 1'b0;
    check("t4_cnt2",    stat_intr_cnt, 3);
    tick(8);

    // Asynchronous reset in the middle of a request
    dla_intr_i = 1'b1;
    tick(2);
    check("t5_irq", interrupt, 1);
    #2 ap_rst = 1'b1;
    #1;
    check("t5_async_irq",  interrupt,     0);
    check("t5_async_pend", stat_pending,  0);
    check("t5_async_cnt",  stat_intr_cnt, 0);
    check("t5_async_ctx",  interrupt_ctx, 0);
    tick(2);
    ap_rst = 1'b0;
    tick(6);
    check("t5_no_irq",  interrupt,    0);
    check("t5_no_pend", stat_pending, 0);
    dla_intr_i = 1'b0;
    tick(1);
    dla_intr_i = 1'b1;
    tick(2);
    check("t5_new_irq", interrupt, 1);
    interrupt_ack = 1'b1;
    tick(1);
    interrupt_ack = 1'b0;
    check("t5_cnt", stat_intr_cnt, 1);
    dla_intr_i = 1'b0;
    tick(8);

    // Spurious ack in IDLE changes nothing
    interrupt_ack = 1'b1;
    tick(1);
    interrupt_ack = 1'b0;
    check("t6_spur_cnt", stat_intr_cnt, 1);
    check("t6_spur_irq", interrupt,     0);
    tick(1);
    check("t6_spur_irq2", interrupt, 0);

    // Saturation at all-ones
    repeat (14) service();
    check("t6_cnt_max", stat_intr_cnt, 4'hF);
    service();
    check("t6_cnt_sat", stat_intr_cnt, 4'hF);

    // Spurious ack together with clear at the saturated count
    interrupt_ack = 1'b1;
    cfg_clr_stat  = 1'b1;
    tick(1);
    interrupt_ack = 1'b0;
    cfg_clr_stat  = 1'b0;
    check("t6_clr_cnt",  stat_intr_cnt, 0);
    check("t6_clr_irq",  interrupt,     0);
    check("t6_clr_pend", stat_pending,  0);
    tick(2);
    check("t6_idle_irq", interrupt, 0);

    // Clear wins over an increment in the same cycle
    dla_intr_i = 1'b1;
    tick(2);
    check("t7_irq", interrupt, 1);
    interrupt_ack = 1'b1;
    cfg_clr_stat  = 1'b1;
    tick(1);
    interrupt_ack = 1'b0;
    cfg_clr_stat  = 1'b0;
    check("t7_clr_prio", stat_intr_cnt, 0);
    check("t7_irq_drop", interrupt,     0);
    dla_intr_i = 1'b0;
    tick(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
